// File: rtl/sd_cmd_ctrl.sv
// rtl/sd_cmd_ctrl.sv - SD CMD-line controller: frame serializer, response receiver and checker
module sd_cmd_ctrl #(
  parameter int TIMEOUT_STROBES = 64
) (
  input  logic        clk,
  input  logic        ex_resetn,
  input  logic        sd_clk_en,
  input  logic        soft_reset_cmd,
  input  logic        cmd_start,
  input  logic [15:0] cmd_in,
  input  logic [31:0] arg_in,
  input  logic        sd_cmd_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe,
  output logic        cmd_inhibit,
  output logic [31:0] resp0_out,
  output logic [31:0] resp1_out,
  output logic [31:0] resp2_out,
  output logic [31:0] resp3_out,
  output logic        resp_en,
  output logic        cmd_complete,
  output logic        err_timeout,
  output logic        err_crc,
  output logic        err_index,
  output logic        err_end_bit
);

  localparam int TW = $clog2(TIMEOUT_STROBES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_RESP, S_RECV, S_FINISH} state_e;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  state_e        state_q;
  logic [46:0]   frame_q;
  logic [7:0]    bit_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [126:0]  rx_q;
  logic [6:0]    crc_q;
  logic [5:0]    index_q;
  logic          idx_chk_q, crc_chk_q, long_q, none_q;
  logic          cmd_o_q, oe_q, inhibit_q;
  logic [31:0]   resp0_q, resp1_q, resp2_q, resp3_q;
  logic          resp_en_q, cmd_complete_q, err_timeout_q, err_crc_q, err_index_q, err_end_q;

  logic [39:0]   frame40_d;
  logic [6:0]    crc_tx_d;
  logic [47:0]   frame_d;
  logic [127:0]  rx_d;
  logic [7:0]    rx_cnt_d;
  logic [7:0]    rx_total_d;
  logic          crc_upd_d, crc_bad_d, idx_bad_d, end_bad_d;
  logic          unused_ok;

  assign unused_ok = ^{cmd_in[15:14], cmd_in[7:5], cmd_in[2]};

  // Build the outgoing frame and its CRC from the live register values
  always_comb begin
    frame40_d = {2'b01, cmd_in[13:8], arg_in};
    crc_tx_d  = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      crc_tx_d = crc7_step(crc_tx_d, frame40_d[i]);
    end
    frame_d = {frame40_d, crc_tx_d, 1'b1};
  end

  // Receive-side view including the bit being sampled on this strobe, plus the checks on it
  always_comb begin
    rx_d       = {rx_q, sd_cmd_i};
    rx_cnt_d   = bit_cnt_q + 8'd1;
    rx_total_d = long_q ? 8'd136 : 8'd48;
    crc_upd_d  = long_q ? (rx_cnt_d >= 8'd9 && rx_cnt_d <= 8'd128) : (rx_cnt_d <= 8'd40);
    crc_bad_d  = crc_chk_q && (crc_q != rx_d[7:1]);
    idx_bad_d  = !long_q && idx_chk_q && (rx_d[45:40] != index_q);
    end_bad_d  = !rx_d[0];
  end

  // Command FSM with all outputs registered; result pulses live for the FINISH cycle only
  always_ff @(posedge clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state_q        <= S_IDLE;
      frame_q        <= '0;
      bit_cnt_q      <= '0;
      to_cnt_q       <= '0;
      rx_q           <= '0;
      crc_q          <= '0;
      index_q        <= '0;
      idx_chk_q      <= 1'b0;
      crc_chk_q      <= 1'b0;
      long_q         <= 1'b0;
      none_q         <= 1'b0;
      cmd_o_q        <= 1'b1;
      oe_q           <= 1'b0;
      inhibit_q      <= 1'b0;
      resp0_q        <= '0;
      resp1_q        <= '0;
      resp2_q        <= '0;
      resp3_q        <= '0;
      resp_en_q      <= 1'b0;
      cmd_complete_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_crc_q      <= 1'b0;
      err_index_q    <= 1'b0;
      err_end_q      <= 1'b0;
    end else begin
      resp_en_q      <= 1'b0;
      cmd_complete_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_crc_q      <= 1'b0;
      err_index_q    <= 1'b0;
      err_end_q      <= 1'b0;
      if (soft_reset_cmd) begin
        state_q   <= S_IDLE;
        oe_q      <= 1'b0;
        cmd_o_q   <= 1'b1;
        inhibit_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (cmd_start) begin
            frame_q   <= frame_d[46:0];
            cmd_o_q   <= frame_d[47];
            oe_q      <= 1'b1;
            inhibit_q <= 1'b1;
            bit_cnt_q <= '0;
            index_q   <= cmd_in[13:8];
            idx_chk_q <= cmd_in[4];
            crc_chk_q <= cmd_in[3];
            long_q    <= (cmd_in[1:0] == 2'b01);
            none_q    <= (cmd_in[1:0] == 2'b00);
            state_q   <= S_SEND;
          end
          S_SEND: if (sd_clk_en) begin
            if (bit_cnt_q == 8'd47) begin
              oe_q     <= 1'b0;
              cmd_o_q  <= 1'b1;
              to_cnt_q <= '0;
              if (none_q) begin
                cmd_complete_q <= 1'b1;
                state_q        <= S_FINISH;
              end else begin
                state_q <= S_WAIT_RESP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
              cmd_o_q   <= frame_q[46];
              frame_q   <= {frame_q[45:0], 1'b1};
            end
          end
          S_WAIT_RESP: if (sd_clk_en) begin
            if (!sd_cmd_i) begin
              rx_q      <= rx_d[126:0];
              bit_cnt_q <= 8'd1;
              crc_q     <= '0;
              state_q   <= S_RECV;
            end else if (to_cnt_q == TW'(TIMEOUT_STROBES - 1)) begin
              err_timeout_q <= 1'b1;
              state_q       <= S_FINISH;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          S_RECV: if (sd_clk_en) begin
            rx_q      <= rx_d[126:0];
            bit_cnt_q <= rx_cnt_d;
            if (crc_upd_d) crc_q <= crc7_step(crc_q, sd_cmd_i);
            if (rx_cnt_d == rx_total_d) begin
              resp0_q        <= rx_d[39:8];
              resp1_q        <= long_q ? rx_d[71:40] : 32'd0;
              resp2_q        <= long_q ? rx_d[103:72] : 32'd0;
              resp3_q        <= long_q ? {8'h00, rx_d[127:104]} : 32'd0;
              resp_en_q      <= 1'b1;
              err_crc_q      <= crc_bad_d;
              err_index_q    <= idx_bad_d;
              err_end_q      <= end_bad_d;
              cmd_complete_q <= !(crc_bad_d || idx_bad_d || end_bad_d);
              state_q        <= S_FINISH;
            end
          end
          S_FINISH: begin
            inhibit_q <= 1'b0;
            state_q   <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sd_cmd_o     = cmd_o_q;
  assign sd_cmd_oe    = oe_q;
  assign cmd_inhibit  = inhibit_q;
  assign resp0_out    = resp0_q;
  assign resp1_out    = resp1_q;
  assign resp2_out    = resp2_q;
  assign resp3_out    = resp3_q;
  assign resp_en      = resp_en_q;
  assign cmd_complete = cmd_complete_q;
  assign err_timeout  = err_timeout_q;
  assign err_crc      = err_crc_q;
  assign err_index    = err_index_q;
  assign err_end_bit  = err_end_q;

endmodule
